// File: rtl/fractal_sync_rf_sched.sv
// Round-robin scheduler that maps synchronization requesters onto the RF
// ports of the back-routing register file. It never issues two operations to
// the same index in one cycle. It captures barrier completions into per-port
// done slots, which use valid/ready back-pressure.

package fractal_sync_pkg;
  localparam int unsigned SD_WIDTH = 32'd2;
endpackage

module fractal_sync_rf_sched #(
  parameter int unsigned N_REQ     = 32'd4,
  parameter int unsigned N_PORTS   = 32'd2,
  parameter int unsigned IDX_WIDTH = 32'd2,
  parameter int unsigned SD_WIDTH  = fractal_sync_pkg::SD_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i    [N_REQ],
  output logic                 req_ready_o    [N_REQ],
  input  logic                 req_set_i      [N_REQ],
  input  logic [IDX_WIDTH-1:0] req_idx_i      [N_REQ],
  input  logic [SD_WIDTH-1:0]  req_sd_i       [N_REQ],
  output logic                 rf_check_o     [N_PORTS],
  output logic                 rf_set_o       [N_PORTS],
  output logic                 rf_idx_valid_o [N_PORTS],
  output logic [IDX_WIDTH-1:0] rf_idx_o       [N_PORTS],
  output logic [SD_WIDTH-1:0]  rf_sd_o        [N_PORTS],
  input  logic                 rf_present_i   [N_PORTS],
  input  logic [SD_WIDTH-1:0]  rf_sd_i        [N_PORTS],
  output logic                 done_valid_o   [N_PORTS],
  input  logic                 done_ready_i   [N_PORTS],
  output logic [IDX_WIDTH-1:0] done_idx_o     [N_PORTS],
  output logic [SD_WIDTH-1:0]  done_sd_o      [N_PORTS]
);

  localparam int unsigned RR_W = (N_REQ > 32'd1) ? $clog2(N_REQ) : 32'd1;
  localparam int unsigned P_W  = (N_PORTS > 32'd1) ? $clog2(N_PORTS) : 32'd1;

  logic [RR_W-1:0]      r_rr;
  logic [RR_W-1:0]      w_rr_next;
  logic                 w_usable    [N_PORTS];
  logic                 w_gnt_valid [N_PORTS];
  logic                 w_gnt_set   [N_PORTS];
  logic [IDX_WIDTH-1:0] w_gnt_idx   [N_PORTS];
  logic [SD_WIDTH-1:0]  w_gnt_sd    [N_PORTS];
  logic                 w_req_ready [N_REQ];
  logic                 w_load      [N_PORTS];
  logic                 r_done_valid [N_PORTS];
  logic [IDX_WIDTH-1:0] r_done_idx   [N_PORTS];
  logic [SD_WIDTH-1:0]  r_done_sd    [N_PORTS];

  // A port can take a new operation only if its done slot is free or draining now.
  always_comb begin
    for (int unsigned p = 32'd0; p < N_PORTS; p++) begin
      w_usable[p] = !r_done_valid[p] || done_ready_i[p];
    end
  end

  // Round-robin scan from r_rr: k-th eligible requester takes the k-th usable port.
  always_comb begin : scan
    logic [RR_W-1:0] v_r;
    logic [P_W-1:0]  v_sel;
    int unsigned     v_next_port;
    logic            v_found;
    logic            v_conflict;
    for (int unsigned p = 32'd0; p < N_PORTS; p++) begin
      w_gnt_valid[p] = 1'b0;
      w_gnt_set[p]   = 1'b0;
      w_gnt_idx[p]   = '0;
      w_gnt_sd[p]    = '0;
    end
    for (int unsigned r = 32'd0; r < N_REQ; r++) begin
      w_req_ready[r] = 1'b0;
    end
    w_rr_next   = r_rr;
    v_r         = '0;
    v_sel       = '0;
    v_next_port = 32'd0;
    v_found     = 1'b0;
    v_conflict  = 1'b0;
    if (rst_ni) begin
      for (int unsigned k = 32'd0; k < N_REQ; k++) begin
        v_r        = RR_W'((32'(r_rr) + k) % N_REQ);
        v_conflict = 1'b0;
        for (int unsigned q = 32'd0; q < N_PORTS; q++) begin
          if (w_gnt_valid[q] && (w_gnt_idx[q] == req_idx_i[v_r])) begin
            v_conflict = 1'b1;
          end else begin
            v_conflict = v_conflict;
          end
        end
        v_found = 1'b0;
        v_sel   = '0;
        for (int unsigned q = 32'd0; q < N_PORTS; q++) begin
          if (!v_found && (q >= v_next_port) && w_usable[q]) begin
            v_found = 1'b1;
            v_sel   = P_W'(q);
          end else begin
            v_found = v_found;
          end
        end
        if (req_valid_i[v_r] && !v_conflict && v_found) begin
          w_req_ready[v_r]   = 1'b1;
          w_gnt_valid[v_sel] = 1'b1;
          w_gnt_set[v_sel]   = req_set_i[v_r];
          w_gnt_idx[v_sel]   = req_idx_i[v_r];
          w_gnt_sd[v_sel]    = req_sd_i[v_r];
          v_next_port        = 32'(v_sel) + 32'd1;
          w_rr_next          = RR_W'((32'(v_r) + 32'd1) % N_REQ);
        end else begin
          v_next_port = v_next_port;
        end
      end
    end else begin
      w_rr_next = '0;
    end
  end

  // Drive RF ports and requester grants; ungranted ports stay all-zero.
  always_comb begin
    for (int unsigned p = 32'd0; p < N_PORTS; p++) begin
      rf_idx_valid_o[p] = w_gnt_valid[p];
      rf_check_o[p]     = w_gnt_valid[p] && !w_gnt_set[p];
      rf_set_o[p]       = w_gnt_valid[p] && w_gnt_set[p];
      rf_idx_o[p]       = w_gnt_idx[p];
      rf_sd_o[p]        = w_gnt_sd[p];
      w_load[p]         = w_gnt_valid[p] && !w_gnt_set[p] && rf_present_i[p];
      done_valid_o[p]   = r_done_valid[p];
      done_idx_o[p]     = r_done_idx[p];
      done_sd_o[p]      = r_done_sd[p];
    end
    for (int unsigned r = 32'd0; r < N_REQ; r++) begin
      req_ready_o[r] = w_req_ready[r];
    end
  end

  // Round-robin pointer moves past the last granted requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else begin
      r_rr <= w_rr_next;
    end
  end

  // Done slots: a completing check reloads the slot, and reload beats a drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 32'd0; p < N_PORTS; p++) begin
        r_done_valid[p] <= 1'b0;
        r_done_idx[p]   <= '0;
        r_done_sd[p]    <= '0;
      end
    end else begin
      for (int unsigned p = 32'd0; p < N_PORTS; p++) begin
        if (w_load[p]) begin
          r_done_valid[p] <= 1'b1;
          r_done_idx[p]   <= w_gnt_idx[p];
          r_done_sd[p]    <= rf_sd_i[p] | w_gnt_sd[p];
        end else if (r_done_valid[p] && done_ready_i[p]) begin
          r_done_valid[p] <= 1'b0;
          r_done_idx[p]   <= '0;
          r_done_sd[p]    <= '0;
        end else begin
          r_done_valid[p] <= r_done_valid[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_fractal_sync_rf_sched.sv
// Directed bench for fractal_sync_rf_sched with a small behavioural RF model:
// set marks a register present; check on an absent register stores it;
// check on a present register completes the barrier and clears it.

module tb_fractal_sync_rf_sched;

  logic       clk;
  logic       rst_n;
  logic       req_valid [4];
  logic       req_ready [4];
  logic       req_set   [4];
  logic [1:0] req_idx   [4];
  logic [1:0] req_sd    [4];
  logic       rf_check  [2];
  logic       rf_set    [2];
  logic       rf_iv     [2];
  logic [1:0] rf_idx    [2];
  logic [1:0] rf_sd_o   [2];
  logic       rf_present[2];
  logic [1:0] rf_sd_i   [2];
  logic       done_valid[2];
  logic       done_ready[2];
  logic [1:0] done_idx  [2];
  logic [1:0] done_sd   [2];

  logic       m_present [4];
  logic [1:0] m_sd      [4];

  int n_vec = 0;
  int n_err = 0;

  fractal_sync_rf_sched dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_set_i      (req_set),
    .req_idx_i      (req_idx),
    .req_sd_i       (req_sd),
    .rf_check_o     (rf_check),
    .rf_set_o       (rf_set),
    .rf_idx_valid_o (rf_iv),
    .rf_idx_o       (rf_idx),
    .rf_sd_o        (rf_sd_o),
    .rf_present_i   (rf_present),
    .rf_sd_i        (rf_sd_i),
    .done_valid_o   (done_valid),
    .done_ready_i   (done_ready),
    .done_idx_o     (done_idx),
    .done_sd_o      (done_sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RF model: present/sd are read combinationally at the port index.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rf_present[p] = m_present[rf_idx[p]];
      rf_sd_i[p]    = m_sd[rf_idx[p]];
    end
  end

  // RF model update on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_present[i] <= 1'b0;
        m_sd[i]      <= 2'b00;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rf_iv[p]) begin
          if (rf_set[p]) begin
            m_present[rf_idx[p]] <= 1'b1;
            m_sd[rf_idx[p]]      <= rf_sd_o[p];
          end else if (m_present[rf_idx[p]]) begin
            m_present[rf_idx[p]] <= 1'b0;
            m_sd[rf_idx[p]]      <= 2'b00;
          end else begin
            m_present[rf_idx[p]] <= 1'b1;
            m_sd[rf_idx[p]]      <= rf_sd_o[p];
          end
        end
      end
    end
  end

  function automatic logic [3:0] rdy();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = req_ready[i];
    return v;
  endfunction

  function automatic logic [1:0] ivs();
    logic [1:0] v;
    for (int i = 0; i < 2; i++) v[i] = rf_iv[i];
    return v;
  endfunction

  function automatic logic [1:0] dvs();
    logic [1:0] v;
    for (int i = 0; i < 2; i++) v[i] = done_valid[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int r, input logic s, input logic [1:0] idx, input logic [1:0] sd);
    req_valid[r] = 1'b1;
    req_set[r]   = s;
    req_idx[r]   = idx;
    req_sd[r]    = sd;
  endtask

  task automatic drop(input int r);
    req_valid[r] = 1'b0;
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = 1'b0;
      req_set[i]   = 1'b0;
      req_idx[i]   = 2'b00;
      req_sd[i]    = 2'b00;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    clr();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    done_ready[0] = 1'b1;
    done_ready[1] = 1'b1;
    // Reset state, with a request pending
    req(0, 1'b0, 2'd1, 2'b01);
    #2;
    chk("rst_ready", rdy(), 4'b0000);
    chk("rst_rf_iv", ivs(), 2'b00);
    chk("rst_done_valid", dvs(), 2'b00);
    chk("rst_done_idx0", done_idx[0], 2'd0);
    tick();
    rst_n = 1'b1;
    clr();

    // Two checks on idx 1 complete the barrier
    req(0, 1'b0, 2'd1, 2'b01);
    #1;
    chk("t1_ready", rdy(), 4'b0001);
    chk("t1_iv", ivs(), 2'b01);
    chk("t1_idx0", rf_idx[0], 2'd1);
    chk("t1_check0", rf_check[0], 1'b1);
    chk("t1_present0", rf_present[0], 1'b0);
    tick();
    chk("t1_nodone", dvs(), 2'b00);
    clr();
    tick();
    chk("t1_idle_nodone", dvs(), 2'b00);
    req(2, 1'b0, 2'd1, 2'b10);
    #1;
    chk("t1_ready2", rdy(), 4'b0100);
    chk("t1_present2", rf_present[0], 1'b1);
    tick();
    chk("t1_done_valid", dvs(), 2'b01);
    chk("t1_done_idx", done_idx[0], 2'd1);
    chk("t1_done_sd", done_sd[0], 2'b11);
    clr();
    tick();
    chk("t1_drained", dvs(), 2'b00);
    rst_pulse();

    // Four distinct requesters, round-robin across two cycles
    for (int r = 0; r < 4; r++) req(r, 1'b1, 2'(r), 2'(r));
    #1;
    chk("t2_c1_ready", rdy(), 4'b0011);
    chk("t2_c1_idx0", rf_idx[0], 2'd0);
    chk("t2_c1_idx1", rf_idx[1], 2'd1);
    chk("t2_c1_set1", rf_set[1], 1'b1);
    tick();
    chk("t2_set_nodone", dvs(), 2'b00);
    drop(0);
    drop(1);
    #1;
    chk("t2_c2_ready", rdy(), 4'b1100);
    chk("t2_c2_idx0", rf_idx[0], 2'd2);
    chk("t2_c2_idx1", rf_idx[1], 2'd3);
    tick();
    for (int r = 0; r < 4; r++) req(r, 1'b1, 2'(r), 2'(r));
    #1;
    chk("t2_c3_ready", rdy(), 4'b0011);
    tick();
    rst_pulse();

    // Same-index contention
    req(0, 1'b0, 2'd2, 2'b01);
    req(1, 1'b0, 2'd2, 2'b10);
    #1;
    chk("t3_ready", rdy(), 4'b0001);
    chk("t3_iv", ivs(), 2'b01);
    tick();
    chk("t3_nodone", dvs(), 2'b00);
    drop(0);
    #1;
    chk("t3_ready_next", rdy(), 4'b0010);
    chk("t3_idx0", rf_idx[0], 2'd2);
    chk("t3_present", rf_present[0], 1'b1);
    tick();
    chk("t3_done_valid", dvs(), 2'b01);
    chk("t3_done_idx", done_idx[0], 2'd2);
    chk("t3_done_sd", done_sd[0], 2'b11);
    drop(1);

    // Slot 0 stalled: only port 1 is usable
    done_ready[0] = 1'b0;
    req(0, 1'b1, 2'd0, 2'b01);
    req(2, 1'b1, 2'd1, 2'b01);
    req(3, 1'b1, 2'd3, 2'b01);
    #1;
    chk("t4_ready", rdy(), 4'b0100);
    chk("t4_iv", ivs(), 2'b10);
    chk("t4_idx1", rf_idx[1], 2'd1);
    tick();
    chk("t4_held", dvs(), 2'b01);
    drop(2);
    #1;
    chk("t4_ready_stalled", rdy(), 4'b1000);
    chk("t4_iv_stalled", ivs(), 2'b10);
    done_ready[0] = 1'b1;
    #1;
    chk("t4_ready_free", rdy(), 4'b1001);
    chk("t4_iv_free", ivs(), 2'b11);
    chk("t4_idx0_free", rf_idx[0], 2'd3);
    chk("t4_idx1_free", rf_idx[1], 2'd0);
    tick();
    chk("t4_drained", dvs(), 2'b00);
    clr();
    tick();
    rst_pulse();

    // Set then check then check on idx 3
    req(0, 1'b1, 2'd3, 2'b01);
    #1;
    chk("t5_set0", rf_set[0], 1'b1);
    chk("t5_check0", rf_check[0], 1'b0);
    tick();
    chk("t5_set_nodone", dvs(), 2'b00);
    drop(0);
    req(1, 1'b0, 2'd3, 2'b10);
    #1;
    chk("t5_ready1", rdy(), 4'b0010);
    chk("t5_present", rf_present[0], 1'b1);
    tick();
    chk("t5_done_valid", dvs(), 2'b01);
    chk("t5_done_idx", done_idx[0], 2'd3);
    chk("t5_done_sd", done_sd[0], 2'b11);
    drop(1);
    req(2, 1'b0, 2'd3, 2'b01);
    #1;
    chk("t5_ready2", rdy(), 4'b0100);
    chk("t5_cleared", rf_present[0], 1'b0);
    tick();
    chk("t5_second_nodone", dvs(), 2'b00);
    rst_pulse();

    // Asynchronous reset with done slot 1 full and requests pending
    req(0, 1'b1, 2'd0, 2'b01);
    req(1, 1'b1, 2'd1, 2'b01);
    #1;
    chk("t6_set_ready", rdy(), 4'b0011);
    tick();
    clr();
    done_ready[1] = 1'b0;
    req(2, 1'b0, 2'd0, 2'b10);
    req(3, 1'b0, 2'd1, 2'b10);
    #1;
    chk("t6_check_ready", rdy(), 4'b1100);
    tick();
    chk("t6_done_both", dvs(), 2'b11);
    chk("t6_done_idx1", done_idx[1], 2'd1);
    chk("t6_done_sd1", done_sd[1], 2'b11);
    clr();
    req(1, 1'b0, 2'd2, 2'b01);
    #1;
    chk("t6_one_port", rdy(), 4'b0010);
    chk("t6_one_port_iv", ivs(), 2'b01);
    tick();
    chk("t6_slot1_held", dvs(), 2'b10);
    clr();
    req(0, 1'b0, 2'd0, 2'b01);
    req(2, 1'b0, 2'd3, 2'b01);
    req(3, 1'b0, 2'd2, 2'b01);
    #1;
    chk("t6_pre_rst_ready", rdy(), 4'b0100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_done_valid", dvs(), 2'b00);
    chk("t6_rst_done_idx1", done_idx[1], 2'd0);
    chk("t6_rst_done_sd1", done_sd[1], 2'b00);
    chk("t6_rst_ready", rdy(), 4'b0000);
    chk("t6_rst_iv", ivs(), 2'b00);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_post_ready", rdy(), 4'b0101);
    chk("t6_post_idx0", rf_idx[0], 2'd0);
    chk("t6_post_idx1", rf_idx[1], 2'd3);
    tick();
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fractal_sync_rf_sched.md
# fractal_sync_rf_sched

Multi-requester scheduler for the fractal synchronization multi-port register file with back-routing. It arbitrates N_REQ synchronization requesters onto the N_PORTS RF ports each cycle with round-robin fairness. Within one cycle it never issues two operations to the same register index. It also registers barrier-completion events (check hitting a present register) into per-port output slots with valid/ready back-pressure. It sits between the node's requester-side sync interfaces and the back-routing register file instance.

## Interface
- N_REQ, 4, number of requesters (≥1)
- N_PORTS, 2, RF ports driven (≥1, ≤N_REQ)
- IDX_WIDTH, 2, RF index width
- SD_WIDTH, fractal_sync_pkg::SD_WIDTH, source/destination vector width
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i[N_REQ]  in  1  request pending
- req_ready_o[N_REQ]  out  1  request granted this cycle (combinational)
- req_set_i[N_REQ]  in  1  0 = check op, 1 = set op
- req_idx_i[N_REQ]  in  IDX_WIDTH  target register index
- req_sd_i[N_REQ]  in  SD_WIDTH  requester source/destination vector
- rf_check_o[N_PORTS], rf_set_o[N_PORTS], rf_idx_valid_o[N_PORTS]  out  1  RF port controls
- rf_idx_o[N_PORTS]  out  IDX_WIDTH  RF port index
- rf_sd_o[N_PORTS]  out  SD_WIDTH  RF port sd
- rf_present_i[N_PORTS]  in  1  RF present, asynchronous, same cycle
- rf_sd_i[N_PORTS]  in  SD_WIDTH  RF stored sd, same cycle
- done_valid_o[N_PORTS]  out  1  completed barrier available
- done_ready_i[N_PORTS]  in  1  consumer accepts
- done_idx_o[N_PORTS]  out  IDX_WIDTH  completed index
- done_sd_o[N_PORTS]  out  SD_WIDTH  merged sd of completed barrier

## Operation
- Port p is usable when !done_valid_o[p] || done_ready_i[p].
- Scan requesters starting at pointer rr_q, in order rr_q, rr_q+1 … mod N_REQ. The k-th eligible winner goes to the k-th usable port in ascending port order. The scan stops when usable ports are exhausted.
- A requester is eligible when its req_valid_i is high and its req_idx_i differs from every index already granted this cycle. A requester that is skipped keeps its request and competes next cycle.
- For each granted requester r on port p: req_ready_o[r]=1, rf_idx_valid_o[p]=1, rf_idx_o[p]=req_idx_i[r], rf_sd_o[p]=req_sd_i[r], rf_check_o[p]=!req_set_i[r], rf_set_o[p]=req_set_i[r].
- Ungranted ports drive all controls 0, idx 0 and sd 0.
- Completion: a granted check with rf_present_i[p]=1 loads slot p on the next edge with done_valid=1, done_idx=rf_idx_o[p] and done_sd=rf_sd_i[p]|req_sd_i[r].
- A check with present=0 and any set op produce no completion. Neither loads slot p.
- Slot p is cleared on done_valid_o[p]&&done_ready_i[p] unless it is reloaded in the same cycle; reload wins.
- Pointer update: if any grant occurs, rr_q <= (last granted requester index + 1) mod N_REQ. Otherwise rr_q holds.
- While rst_ni=0: all req_ready_o=0 and all RF controls are 0.

## Timing
- Reset values: rr_q=0, done_valid_o=0, done_idx_o=0, done_sd_o=0, req_ready_o=0, RF controls 0.
- Grant and RF drive are combinational in cycle T. The RF updates and done_valid_o rises at edge T+1, so completion latency is 1 cycle.
- Handshake: a request is consumed only in a cycle where req_valid_i&&req_ready_o. The scheduler holds no request state.
- Done slot back-to-back: with done_ready_i=1 held, port p can complete every cycle.
- Same-index contention: at most one operation per index per cycle. This guarantees check toggles are never merged by the RF.
- Reset asserted mid-operation clears done slots immediately (asynchronous) and returns rr_q to 0.

## Test plan
- Reset, then req 0 check idx 1 sd 01 at T, req 2 check idx 1 sd 10 at T+2:
  - T+1: no done.
  - T+3: done_valid_o[0]=1, done_idx=1, done_sd=11.
- All 4 requesters valid, distinct idx 0..3, rr_q=0, ports free:
  - Cycle 1 grants req0→p0 and req1→p1; rr_q=2.
  - Cycle 2 grants req2 and req3; rr_q=0.
- Req 0 and req 1 both check idx 2 in one cycle:
  - Only req 0 is granted; req1 is granted next cycle.
  - req 1 produces a completion one cycle after its grant.
- Slot 0 done_valid=1 with done_ready_i[0]=0 and 3 valid requesters:
  - Only one grant per cycle, on p1.
  - Raising done_ready_i[0] restores 2 grants in the same cycle.
- Set op on idx 3, then a check on idx 3:
  - The set gives no done.
  - The check yields done, then the register is cleared.
  - A second check on idx 3 yields no done.
- Reset asserted while done_valid_o[1]=1 and requests pending:
  - Outputs go to 0 immediately.
  - After release the first grant starts at requester 0.
